// File: rtl/interp_halfband_fir_pkg.sv
// Shared constants, FSM state type and coefficient table for the
// halfband interpolation FIR.
package interp_halfband_fir_pkg;

  localparam int DW        = 18;
  localparam int CW        = 18;
  localparam int COEF_FRAC = 16;
  localparam int AW        = 40;
  localparam int NTAPS     = 15;
  localparam int PW        = DW + 1;
  localparam int MW        = PW + CW;

  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  // Upper half of the symmetric impulse response; c[k] == c[14-k].
  function automatic logic signed [CW-1:0] coef(input logic [2:0] k);
    case (k)
      3'd0:    coef = -18'sd1232;
      3'd2:    coef = 18'sd3500;
      3'd4:    coef = -18'sd10500;
      3'd6:    coef = 18'sd41000;
      3'd7:    coef = 18'sd65536;
      default: coef = '0;
    endcase
  endfunction

endpackage

// File: rtl/fir_mac_round_sat.sv
// Time-shared pre-add / multiply / accumulate with rounding and
// saturation of the accumulated result to the output width.
module fir_mac_round_sat
  import interp_halfband_fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic                 last_i,
  input  logic signed [DW-1:0] tap_a_i,
  input  logic signed [DW-1:0] tap_b_i,
  input  logic signed [CW-1:0] coef_i,
  output logic signed [DW-1:0] y_sat_o
);

  localparam logic signed [AW-1:0] ROUND_K = AW'(1) << (COEF_FRAC - 1);
  localparam logic signed [AW-1:0] HI_W = {{(AW-DW){SAT_MAX[DW-1]}}, SAT_MAX};
  localparam logic signed [AW-1:0] LO_W = {{(AW-DW){SAT_MIN[DW-1]}}, SAT_MIN};

  logic signed [PW-1:0] pre;
  logic signed [MW-1:0] prod;
  logic signed [AW-1:0] acc_q, acc_d, rnd_sum, shifted;

  always_comb begin
    // The centre tap has no mirror partner, so it bypasses the pre-add.
    if (last_i) pre = {tap_a_i[DW-1], tap_a_i};
    else        pre = {tap_a_i[DW-1], tap_a_i} + {tap_b_i[DW-1], tap_b_i};
    prod = {{CW{pre[PW-1]}}, pre} * {{PW{coef_i[CW-1]}}, coef_i};

    acc_d = acc_q;
    if (clear_i)   acc_d = '0;
    else if (en_i) acc_d = acc_q + {{(AW-MW){prod[MW-1]}}, prod};

    rnd_sum = acc_q + ROUND_K;
    shifted = rnd_sum >>> COEF_FRAC;
    if (shifted > HI_W)      y_sat_o = SAT_MAX;
    else if (shifted < LO_W) y_sat_o = SAT_MIN;
    else                     y_sat_o = shifted[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/interp_halfband_fir.sv
// 15-tap halfband interpolation FIR: delay line plus an FSM sequencing
// one shared MAC over eight cycles per input sample.
module interp_halfband_fir
  import interp_halfband_fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sam_clk,
  input  logic signed [DW-1:0] x_in,
  output logic signed [DW-1:0] y,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun
);

  state_t               state_q, state_d;
  logic [2:0]           k_q, k_d;
  logic signed [DW-1:0] dl_q [NTAPS];
  logic signed [DW-1:0] y_q, y_sat;
  logic                 y_valid_q, overrun_q, overrun_d;
  logic                 shift, clear, en, y_load, last;
  logic [3:0]           idx_a, idx_b;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    shift     = 1'b0;
    clear     = 1'b0;
    en        = 1'b0;
    y_load    = 1'b0;
    // Samples arriving outside IDLE (including the OUT->IDLE cycle) are dropped.
    overrun_d = overrun_q | (sam_clk && (state_q != IDLE));
    case (state_q)
      IDLE: if (sam_clk) begin
        shift   = 1'b1;
        clear   = 1'b1;
        k_d     = '0;
        state_d = ACC;
      end
      ACC: begin
        en  = 1'b1;
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = OUT;
      end
      OUT: begin
        y_load  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) dl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      y_valid_q <= y_load;
      overrun_q <= overrun_d;
      if (y_load) y_q <= y_sat;
      if (shift) begin
        dl_q[0] <= x_in;
        for (int unsigned i = 1; i < NTAPS; i++) dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign idx_a = {1'b0, k_q};
  assign idx_b = 4'(NTAPS - 1) - idx_a;
  assign last  = (k_q == 3'd7);

  fir_mac_round_sat u_mac (
    .clk     (clk),
    .rst     (reset),
    .clear_i (clear),
    .en_i    (en),
    .last_i  (last),
    .tap_a_i (dl_q[idx_a]),
    .tap_b_i (dl_q[idx_b]),
    .coef_i  (coef(k_q)),
    .y_sat_o (y_sat)
  );

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_interp_halfband_fir.sv
// Directed bench for interp_halfband_fir: impulse, DC, saturation,
// overrun, mid-computation reset and minimum-spacing scenarios.
module tb_interp_halfband_fir;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sam_clk = 1'b0;
  logic signed [17:0] x_in = '0;
  logic signed [17:0] y;
  logic               y_valid, busy, overrun;

  int nvec = 0;
  int nerr = 0;
  int pulse_cnt = 0;

  int exp_imp [16] = '{-1232, 0, 3500, 0, -10500, 0, 41000, 65536,
                       41000, 0, -10500, 0, 3500, 0, -1232, 0};

  interp_halfband_fir dut (
    .clk     (clk),
    .reset   (rst),
    .sam_clk (sam_clk),
    .x_in    (x_in),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (y_valid) pulse_cnt <= pulse_cnt + 1;

  task automatic reset_dut();
    rst = 1'b1; sam_clk = 1'b0; x_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issues one sample, waits (bounded) for y_valid, then pads to 'gap' cycles.
  task automatic do_sample(input int x, input int gap,
                           output int yo, output int lat);
    int cnt;
    sam_clk = 1'b1; x_in = 18'(x);
    @(posedge clk); #1;
    sam_clk = 1'b0; x_in = '0;
    cnt = 0;
    while (!y_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    yo  = int'(y);
    lat = cnt;
    if (gap - 1 - cnt > 0) repeat (gap - 1 - cnt) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sam_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (y !== 18'sd0 || y_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: y=%0d y_valid=%b busy=%b overrun=%b, need 0/0/0/0",
               y, y_valid, busy, overrun);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse(input string tag);
    int yo, lat;
    for (int i = 0; i < 16; i++) begin
      do_sample((i == 0) ? 65536 : 0, 12, yo, lat);
      nvec++;
      if (yo !== exp_imp[i] || lat !== 9) begin
        nerr++;
        $display("FAIL %s[%0d]: y=%0d lat=%0d, need y=%0d lat=9", tag, i, yo, lat, exp_imp[i]);
      end
    end
    nvec++;
    if (y_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s_idle: y_valid=%b busy=%b, need 0/0", tag, y_valid, busy);
    end
  endtask

  task automatic test_dc();
    int yo, lat;
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      do_sample((i % 2 == 0) ? 65536 : 0, 11, yo, lat);
      if (i >= 14) begin
        nvec++;
        if (yo !== 65536) begin
          nerr++;
          $display("FAIL dc[%0d]: y=%0d, need 65536", i, yo);
        end
      end
    end
    repeat (40) @(posedge clk);
    #1;
    nvec++;
    if (int'(y) !== 65536 || y_valid !== 1'b0) begin
      nerr++;
      $display("FAIL dc_hold: y=%0d y_valid=%b, need 65536/0", y, y_valid);
    end
  endtask

  task automatic test_saturation();
    int yo, lat;
    int lvl [2] = '{131071, -131072};
    for (int s = 0; s < 2; s++) begin
      reset_dut();
      for (int i = 0; i < 20; i++) begin
        do_sample(lvl[s], 10, yo, lat);
        if (i >= 15) begin
          nvec++;
          if (yo !== lvl[s]) begin
            nerr++;
            $display("FAIL sat%0d[%0d]: y=%0d, need %0d", s, i, yo, lvl[s]);
          end
        end
      end
    end
  endtask

  task automatic test_overrun();
    int yo, lat, p0;
    reset_dut();
    sam_clk = 1'b1; x_in = 18'sd65536;
    @(posedge clk); #1;
    sam_clk = 1'b0; x_in = '0;
    p0 = pulse_cnt;
    repeat (4) @(posedge clk);
    #1;
    nvec++;
    if (overrun !== 1'b0) begin
      nerr++; $display("FAIL ovr_pre: overrun=%b, need 0", overrun);
    end
    sam_clk = 1'b1; x_in = 18'sd30000;
    @(posedge clk); #1;
    sam_clk = 1'b0; x_in = '0;
    nvec++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      nerr++; $display("FAIL ovr_set: overrun=%b busy=%b, need 1/1", overrun, busy);
    end
    repeat (4) @(posedge clk);
    #1;
    nvec++;
    if (y_valid !== 1'b1 || int'(y) !== -1232) begin
      nerr++; $display("FAIL ovr_out: y_valid=%b y=%0d, need 1/-1232", y_valid, y);
    end
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (pulse_cnt - p0 !== 1) begin
      nerr++; $display("FAIL ovr_pulses: got %0d, need 1", pulse_cnt - p0);
    end
    for (int i = 1; i < 6; i++) begin
      do_sample(0, 12, yo, lat);
      nvec++;
      if (yo !== exp_imp[i] || overrun !== 1'b1) begin
        nerr++;
        $display("FAIL ovr_follow[%0d]: y=%0d overrun=%b, need %0d/1", i, yo, overrun, exp_imp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_acc();
    int yo, lat;
    reset_dut();
    do_sample(65536, 12, yo, lat);
    sam_clk = 1'b1; x_in = 18'sd20000;
    @(posedge clk); #1;
    sam_clk = 1'b0; x_in = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (y !== 18'sd0 || y_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset: y=%0d y_valid=%b busy=%b, need 0/0/0", y, y_valid, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    test_impulse("post_reset");
  endtask

  task automatic test_back_to_back();
    int yo, lat, p0;
    reset_dut();
    p0 = pulse_cnt;
    for (int i = 0; i < 30; i++) begin
      do_sample((i == 0) ? 65536 : 0, 10, yo, lat);
      nvec++;
      if (yo !== ((i < 16) ? exp_imp[i] : 0) || lat !== 9) begin
        nerr++;
        $display("FAIL b2b[%0d]: y=%0d lat=%0d, need %0d/9", i, yo, lat, (i < 16) ? exp_imp[i] : 0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (overrun !== 1'b0 || pulse_cnt - p0 !== 30) begin
      nerr++;
      $display("FAIL b2b_summary: overrun=%b pulses=%0d, need 0/30", overrun, pulse_cnt - p0);
    end
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_dc();
    test_saturation();
    test_overrun();
    test_reset_mid_acc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
